// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: default header widths, the $0 register,
// the stage header type used by the hazard unit, and saturating T_new decrement.
package pipe_pkg;
  localparam int TNEW_W_DEF    = 2;
  localparam int REGADDR_W_DEF = 5;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic                     valid;
    logic                     we;
    logic [REGADDR_W_DEF-1:0] a3;
    logic [TNEW_W_DEF-1:0]    tnew;
  } stage_hdr_t;

  // Callers cast the result back to their own T_new width.
  function automatic logic [31:0] sat_dec(input logic [31:0] x);
    return (x != 32'd0) ? x - 32'd1 : 32'd0;
  endfunction
endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating 32-bit event counter for stage performance monitoring.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush, valid, T_new ageing and
// forwarding qualifiers. Define PIPE_STAGE_PERF_CNT_EN for stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LANES     = 4,
  parameter int CTRL_W    = 16,
  parameter int TNEW_W    = TNEW_W_DEF,
  parameter int REGADDR_W = REGADDR_W_DEF,
  parameter int HOLD_AGES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic                    we_i,
  input  logic [REGADDR_W-1:0]    a3_i,
  input  logic [TNEW_W-1:0]       tnew_i,
  input  logic [CTRL_W-1:0]       ctrl_i,
  input  logic [LANES*DATA_W-1:0] data_i,
  output logic                    valid_o,
  output logic                    we_o,
  output logic [REGADDR_W-1:0]    a3_o,
  output logic [TNEW_W-1:0]       tnew_o,
  output logic [CTRL_W-1:0]       ctrl_o,
  output logic [LANES*DATA_W-1:0] data_o,
  output logic                    fwd_rdy_o,
  output logic                    busy_o
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cnt_o,
  output logic [31:0]             bubble_cnt_o
`endif
);
  logic                    valid_q, valid_d;
  logic                    we_q, we_d;
  logic [REGADDR_W-1:0]    a3_q, a3_d;
  logic [TNEW_W-1:0]       tnew_q, tnew_d;
  logic [CTRL_W-1:0]       ctrl_q, ctrl_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    a3_d    = a3_q;
    tnew_d  = tnew_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      a3_d    = '0;
      tnew_d  = '0;
      ctrl_d  = '0;
      data_d  = '0;
    end else if (stall_i) begin
      if (HOLD_AGES != 0) tnew_d = TNEW_W'(sat_dec(32'(tnew_q)));
    end else begin
      // An invalid instruction must never claim a destination register.
      valid_d = valid_i;
      we_d    = valid_i & we_i;
      a3_d    = valid_i ? a3_i : '0;
      tnew_d  = TNEW_W'(sat_dec(32'(tnew_i)));
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      a3_q    <= '0;
      tnew_q  <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      a3_q    <= a3_d;
      tnew_q  <= tnew_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign we_o    = we_q;
  assign a3_o    = a3_q;
  assign tnew_o  = tnew_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

  logic pending_wr;
  assign pending_wr = valid_q & we_q & (a3_q != REGADDR_W'(ZERO_REG));
  assign fwd_rdy_o  = pending_wr & (tnew_q == '0);
  assign busy_o     = pending_wr & (tnew_q != '0);

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic stall_ev, bubble_ev;
  assign stall_ev  = stall_i & ~flush_i;
  assign bubble_ev = flush_i | (~stall_i & ~valid_i);

  pipe_perf_cnt u_stall_cnt (
    .clk(clk), .reset(reset), .inc_i(stall_ev), .cnt_o(stall_cnt_o)
  );
  pipe_perf_cnt u_bubble_cnt (
    .clk(clk), .reset(reset), .inc_i(bubble_ev), .cnt_o(bubble_cnt_o)
  );
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: two instances (ageing hold / frozen hold)
// share stimulus; a behavioural model pushes expected state, a monitor compares.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 32, LA = 4, LB = 2, CW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              stall_i, flush_i, valid_i, we_i;
  logic [4:0]        a3_i;
  logic [1:0]        tnew_i;
  logic [CW-1:0]     ctrl_i;
  logic [LA*DW-1:0]  data_i;

  logic              a_valid, a_we, a_fwd, a_busy;
  logic [4:0]        a_a3;
  logic [1:0]        a_tnew;
  logic [CW-1:0]     a_ctrl;
  logic [LA*DW-1:0]  a_data;
  logic              b_valid, b_we, b_fwd, b_busy;
  logic [4:0]        b_a3;
  logic [1:0]        b_tnew;
  logic [CW-1:0]     b_ctrl;
  logic [LB*DW-1:0]  b_data;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] a_scnt, a_bcnt, b_scnt, b_bcnt;
`endif

  pipe_stage_reg #(.DATA_W(DW), .LANES(LA), .CTRL_W(CW), .HOLD_AGES(1)) dut_a (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .we_i(we_i), .a3_i(a3_i), .tnew_i(tnew_i),
    .ctrl_i(ctrl_i), .data_i(data_i),
    .valid_o(a_valid), .we_o(a_we), .a3_o(a_a3), .tnew_o(a_tnew),
    .ctrl_o(a_ctrl), .data_o(a_data), .fwd_rdy_o(a_fwd), .busy_o(a_busy)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .stall_cnt_o(a_scnt), .bubble_cnt_o(a_bcnt)
`endif
  );

  pipe_stage_reg #(.DATA_W(DW), .LANES(LB), .CTRL_W(CW), .HOLD_AGES(0)) dut_b (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .we_i(we_i), .a3_i(a3_i), .tnew_i(tnew_i),
    .ctrl_i(ctrl_i), .data_i(data_i[LB*DW-1:0]),
    .valid_o(b_valid), .we_o(b_we), .a3_o(b_a3), .tnew_o(b_tnew),
    .ctrl_o(b_ctrl), .data_o(b_data), .fwd_rdy_o(b_fwd), .busy_o(b_busy)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .stall_cnt_o(b_scnt), .bubble_cnt_o(b_bcnt)
`endif
  );

  typedef struct {
    stage_hdr_t       hdr;
    logic [1:0]       tnew_b;
    logic [CW-1:0]    ctrl;
    logic [LA*DW-1:0] data;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   nchk = 0, nerr = 0;
  int   n_stall = 0, n_bubble = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] dec2(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : 2'(int'(x) - 1);
  endfunction

  function automatic exp_t zero_state();
    exp_t z;
    z.hdr = '0; z.tnew_b = '0; z.ctrl = '0; z.data = '0;
    return z;
  endfunction

  // Reference model: what the stage must hold after each edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m = zero_state();
      n_stall = 0; n_bubble = 0;
    end else begin
      if (flush_i) begin
        m = zero_state();
        n_bubble++;
      end else if (stall_i) begin
        m.hdr.tnew = dec2(m.hdr.tnew);
        n_stall++;
      end else begin
        m.hdr.valid = valid_i;
        m.hdr.we    = valid_i && we_i;
        m.hdr.a3    = valid_i ? a3_i : 5'd0;
        m.hdr.tnew  = dec2(tnew_i);
        m.tnew_b    = dec2(tnew_i);
        m.ctrl      = ctrl_i;
        m.data      = data_i;
        if (!valid_i) n_bubble++;
      end
      sb.push_back(m);
    end
  end

  // Monitor: the stage presents a result every cycle.
  always @(posedge clk) begin
    exp_t e;
    logic live;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      live = e.hdr.valid && e.hdr.we && (e.hdr.a3 != 5'd0);
      chk("a_valid", 128'(a_valid), 128'(e.hdr.valid));
      chk("a_we",    128'(a_we),    128'(e.hdr.we));
      chk("a_a3",    128'(a_a3),    128'(e.hdr.a3));
      chk("a_tnew",  128'(a_tnew),  128'(e.hdr.tnew));
      chk("a_ctrl",  128'(a_ctrl),  128'(e.ctrl));
      chk("a_data",  a_data,        e.data);
      chk("a_fwd",   128'(a_fwd),   128'(live && e.hdr.tnew == 2'd0));
      chk("a_busy",  128'(a_busy),  128'(live && e.hdr.tnew != 2'd0));
      chk("b_valid", 128'(b_valid), 128'(e.hdr.valid));
      chk("b_a3",    128'(b_a3),    128'(e.hdr.a3));
      chk("b_tnew",  128'(b_tnew),  128'(e.tnew_b));
      chk("b_data",  128'(b_data),  128'(e.data[LB*DW-1:0]));
      chk("b_fwd",   128'(b_fwd),   128'(live && e.tnew_b == 2'd0));
      chk("b_busy",  128'(b_busy),  128'(live && e.tnew_b != 2'd0));
    end
  end

  task automatic drive(input logic st, input logic fl, input logic v, input logic w,
                       input logic [4:0] a3, input logic [1:0] tn, input logic [31:0] d0);
    @(negedge clk);
    stall_i = st; flush_i = fl; valid_i = v; we_i = w;
    a3_i = a3; tnew_i = tn;
    ctrl_i = 16'($urandom);
    data_i = {$urandom, $urandom, $urandom, d0};
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    stall_i = 0; flush_i = 0; valid_i = 0; we_i = 0;
    a3_i = 0; tnew_i = 0; ctrl_i = 0; data_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(a_valid), 128'(0));
    chk("rst_data",  a_data, 128'(0));
    reset = 1'b0;

    // Advance and ageing
    drive(0, 0, 1, 1, 5'd8, 2'd2, 32'h0000_3000);
    after_edge();
    chk("adv_tnew", 128'(a_tnew), 128'(1));
    chk("adv_busy", 128'(a_busy), 128'(1));
    chk("adv_lane0", 128'(a_data[31:0]), 128'(32'h0000_3000));
    drive(0, 0, 1, 1, 5'd8, 2'd0, 32'h0000_3004);
    after_edge();
    chk("adv_fwd", 128'(a_fwd), 128'(1));

    // Hold: ageing instance drains T_new, frozen instance keeps it
    drive(0, 0, 1, 1, 5'd9, 2'd2, 32'hCAFE_0001);
    after_edge();
    chk("hold_load", 128'(a_tnew), 128'(1));
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 5'd0, 2'd3, 32'hDEAD_BEEF);
      after_edge();
      chk("hold_a_tnew", 128'(a_tnew), 128'(0));
      chk("hold_a_fwd",  128'(a_fwd),  128'(1));
      chk("hold_b_tnew", 128'(b_tnew), 128'(1));
      chk("hold_data",   128'(a_data[31:0]), 128'(32'hCAFE_0001));
    end

    // Flush beats stall
    drive(1, 1, 1, 1, 5'd3, 2'd1, 32'h1234_5678);
    after_edge();
    chk("flush_valid", 128'(a_valid), 128'(0));
    chk("flush_data",  a_data, 128'(0));
    chk("flush_busy",  128'(a_busy | a_fwd), 128'(0));

    // $0 and invalid
    drive(0, 0, 1, 1, 5'd0, 2'd0, 32'h1);
    after_edge();
    chk("zero_fwd", 128'(a_fwd), 128'(0));
    drive(0, 0, 1, 1, 5'd0, 2'd3, 32'h2);
    after_edge();
    chk("zero_busy", 128'(a_busy), 128'(0));
    drive(0, 0, 0, 1, 5'd5, 2'd1, 32'h3);
    after_edge();
    chk("inv_we", 128'(a_we), 128'(0));
    chk("inv_a3", 128'(a_a3), 128'(0));

    // Asynchronous reset between edges with loaded contents
    drive(0, 0, 1, 1, 5'd7, 2'd3, 32'h5555_AAAA);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_valid", 128'(a_valid), 128'(0));
    chk("arst_tnew",  128'(a_tnew),  128'(0));
    chk("arst_data",  a_data, 128'(0));
    chk("arst_busy",  128'(a_busy),  128'(0));
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(3) == 0), ($urandom_range(7) == 0), ($urandom_range(4) != 0),
            1'($urandom), 5'($urandom_range(3) == 0 ? 0 : $urandom), 2'($urandom), $urandom);
    end
    drive(0, 0, 0, 0, 5'd0, 2'd0, 32'h0);
    after_edge();
    #2;
    chk("sb_drained", 128'(sb.size()), 128'(0));
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("stall_cnt",  128'(a_scnt), 128'(n_stall));
    chk("bubble_cnt", 128'(a_bcnt), 128'(n_bubble));
    chk("b_stall_cnt", 128'(b_scnt), 128'(n_stall));
`endif
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
